// File: rtl/alu_seq_if.sv
// Handshake bundle between alu_seq and its producer (operands) and consumer (result).
interface alu_seq_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] g;
  logic             zero;
  logic             carry;

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, g, zero, carry
  );

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, g, zero, carry
  );
endinterface

// File: rtl/alu_seq.sv
// Registered eight-op ALU with valid/ready on both sides; MUL runs as a WIDTH-step shift-add.
// state | meaning
// IDLE  | in_ready high, waiting for an operand/op
// BUSY  | MUL in progress, one shift-add step per edge
// DONE  | result held on g/zero/carry until out_ready
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [2:0]     OP_XOR   = 3'b000;
  localparam logic [2:0]     OP_AND   = 3'b001;
  localparam logic [2:0]     OP_OR    = 3'b010;
  localparam logic [2:0]     OP_ADD   = 3'b011;
  localparam logic [2:0]     OP_SUB   = 3'b100;
  localparam logic [2:0]     OP_SHL   = 3'b101;
  localparam logic [2:0]     OP_SHR   = 3'b110;
  localparam logic [2:0]     OP_MUL   = 3'b111;
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_in_ready;
  logic                 w_out_valid;
  logic [WIDTH-1:0]     r_g;
  logic                 r_zero;
  logic                 r_carry;
  logic [SHW-1:0]       r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic                 w_b_big;
  logic [WIDTH-1:0]     w_alu_g;
  logic                 w_alu_c;

  assign w_sum     = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_diff    = {1'b0, bus.a} - {1'b0, bus.b};
  assign w_b_big   = (32'(bus.b) >= 32'(WIDTH));
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_alu_g = '0;
    w_alu_c = 1'b0;
    case (bus.op)
      OP_XOR: w_alu_g = bus.a ^ bus.b;
      OP_AND: w_alu_g = bus.a & bus.b;
      OP_OR:  w_alu_g = bus.a | bus.b;
      OP_ADD: begin
        w_alu_g = w_sum[WIDTH-1:0];
        w_alu_c = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_alu_g = w_diff[WIDTH-1:0];
        w_alu_c = w_diff[WIDTH];
      end
      OP_SHL: w_alu_g = w_b_big ? '0 : (bus.a << bus.b);
      OP_SHR: w_alu_g = w_b_big ? '0 : (bus.a >> bus.b);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = (bus.op == OP_MUL) ? S_BUSY : S_DONE;
      end
      S_BUSY: if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Result registers only move on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_g      <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          if (bus.op == OP_MUL) begin
            r_mcand  <= {{WIDTH{1'b0}}, bus.a};
            r_mplier <= bus.b;
            r_acc    <= '0;
            r_cnt    <= CNT_LAST;
          end else begin
            r_g     <= w_alu_g;
            r_zero  <= (w_alu_g == '0);
            r_carry <= w_alu_c;
          end
        end
        S_BUSY: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (r_cnt == '0) begin
            r_g     <= w_acc_nxt[WIDTH-1:0];
            r_zero  <= (w_acc_nxt[WIDTH-1:0] == '0);
            r_carry <= |w_acc_nxt[2*WIDTH-1:WIDTH];
          end else begin
            r_cnt <= r_cnt - SHW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.g         = r_g;
  assign bus.zero      = r_zero;
  assign bus.carry     = r_carry;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: WIDTH=8 instance checked every cycle against an arithmetic model, WIDTH=3 XOR regression.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8)) bus ();
  alu_seq_if #(.WIDTH(3)) bus3 ();

  alu_seq #(.WIDTH(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
  alu_seq #(.WIDTH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] g;
    logic       z;
    logic       c;
    int         rdy;
  } exp_t;

  exp_t q[$];

  // Expected result from plain integer arithmetic; rdy is the cycle count at which out_valid must show.
  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input int acc_cyc);
    int unsigned x = a;
    int unsigned y = b;
    int unsigned r = 0;
    exp_t e;
    e.c = 1'b0;
    case (op)
      3'd0: r = x ^ y;
      3'd1: r = x & y;
      3'd2: r = x | y;
      3'd3: begin r = x + y; e.c = (r > 255); end
      3'd4: begin r = x - y; e.c = (x < y); end
      3'd5: r = (y >= 8) ? 0 : (x << y);
      3'd6: r = (y >= 8) ? 0 : (x >> y);
      default: begin r = x * y; e.c = (r > 255); end
    endcase
    e.g   = 8'(r);
    e.z   = (e.g == 8'h00);
    e.rdy = acc_cyc + ((op == 3'd7) ? 8 : 0);
    return e;
  endfunction

  logic [7:0] lg = 8'h00;
  logic       lz = 1'b0;
  logic       lc = 1'b0;

  always @(negedge clk) begin : cmp
    bit   idle;
    bit   vexp;
    exp_t e;
    if (!rst) begin
      q.delete();
      lg = 8'h00; lz = 1'b0; lc = 1'b0;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_g",         32'(bus.g),         32'd0);
    end else begin
      idle = (q.size() == 0);
      if (idle) begin
        chk("idle_in_ready",  32'(bus.in_ready),  32'd1);
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_g",         32'(bus.g),         32'(lg));
        chk("idle_zero",      32'(bus.zero),      32'(lz));
        chk("idle_carry",     32'(bus.carry),     32'(lc));
      end else begin
        e    = q[0];
        vexp = (cyc >= e.rdy);
        chk("pend_in_ready", 32'(bus.in_ready),  32'd0);
        chk("out_valid",     32'(bus.out_valid), 32'(vexp));
        if (vexp) begin
          chk("model_g",     32'(bus.g),     32'(e.g));
          chk("model_zero",  32'(bus.zero),  32'(e.z));
          chk("model_carry", 32'(bus.carry), 32'(e.c));
          if (bus.out_ready) begin
            lg = e.g; lz = e.z; lc = e.c;
            void'(q.pop_front());
          end
        end else begin
          chk("busy_g_stable", 32'(bus.g),     32'(lg));
          chk("busy_z_stable", 32'(bus.zero),  32'(lz));
          chk("busy_c_stable", 32'(bus.carry), 32'(lc));
        end
      end
      if (idle && bus.in_valid) q.push_back(model(bus.op, bus.a, bus.b, cyc + 1));
    end
  end

  // elat counts edges after the accept edge before out_valid shows (0 for single-cycle ops).
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eg, input logic ez, input logic ec,
                      input int elat, input int hold, input bit pulse);
    int n = 0;
    @(posedge clk); #1;
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    while (!bus.out_valid && n < 40) begin
      chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
      n++;
      @(negedge clk);
    end
    chk("latency", 32'(n), 32'(elat));
    chk("lit_g", 32'(bus.g), 32'(eg));
    chk("lit_zero", 32'(bus.zero), 32'(ez));
    chk("lit_carry", 32'(bus.carry), 32'(ec));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      bus.in_valid = pulse && (i == 1);
      bus.op = 3'd0; bus.a = 8'hFF; bus.b = 8'h00;
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_g", 32'(bus.g), 32'(eg));
      chk("hold_carry", 32'(bus.carry), 32'(ec));
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("released_valid", 32'(bus.out_valid), 32'd0);
    chk("released_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic send3(input logic [2:0] a, input logic [2:0] b, input logic [2:0] eg, input logic ez);
    @(posedge clk); #1;
    bus3.op = 3'b000; bus3.a = a; bus3.b = b; bus3.in_valid = 1'b1;
    @(posedge clk); #1;
    bus3.in_valid = 1'b0;
    @(negedge clk);
    chk("w3_valid", 32'(bus3.out_valid), 32'd1);
    chk("w3_g", 32'(bus3.g), 32'(eg));
    chk("w3_zero", 32'(bus3.zero), 32'(ez));
    chk("w3_carry", 32'(bus3.carry), 32'd0);
    chk("w3_in_ready", 32'(bus3.in_ready), 32'd0);
    @(posedge clk); #1;
    bus3.out_ready = 1'b1;
    @(posedge clk); #1;
    bus3.out_ready = 1'b0;
    @(negedge clk);
    chk("w3_released", 32'(bus3.out_valid), 32'd0);
  endtask

  initial begin
    bus.in_valid = 1'b0;  bus.out_ready = 1'b0;  bus.op = 3'd0;  bus.a = 8'h00;  bus.b = 8'h00;
    bus3.in_valid = 1'b0; bus3.out_ready = 1'b0; bus3.op = 3'd0; bus3.a = 3'd0;  bus3.b = 3'd0;
    #2 rst = 1'b0;
    #1;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_in_ready",  32'(bus.in_ready),  32'd1);
    chk("reset_g",         32'(bus.g),         32'd0);
    chk("reset_zero",      32'(bus.zero),      32'd0);
    chk("reset_carry",     32'(bus.carry),     32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    send3(3'b001, 3'b011, 3'b010, 1'b0);
    send3(3'b101, 3'b001, 3'b100, 1'b0);
    send3(3'b111, 3'b111, 3'b000, 1'b1);

    send(3'd3, 8'hF0, 8'h20, 8'h10, 1'b0, 1'b1, 0, 0, 1'b0);
    send(3'd4, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b1, 0, 0, 1'b0);
    send(3'd4, 8'h07, 8'h07, 8'h00, 1'b1, 1'b0, 0, 0, 1'b0);
    send(3'd7, 8'd13, 8'd11, 8'h8F, 1'b0, 1'b0, 8, 0, 1'b0);
    send(3'd7, 8'h20, 8'h10, 8'h00, 1'b1, 1'b1, 8, 0, 1'b0);
    send(3'd1, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 0, 5, 1'b1);
    send(3'd5, 8'h81, 8'd1, 8'h02, 1'b0, 1'b0, 0, 0, 1'b0);
    send(3'd6, 8'h81, 8'd7, 8'h01, 1'b0, 1'b0, 0, 0, 1'b0);
    send(3'd5, 8'h81, 8'd8, 8'h00, 1'b1, 1'b0, 0, 0, 1'b0);
    send(3'd2, 8'h50, 8'h0A, 8'h5A, 1'b0, 1'b0, 0, 0, 1'b0);
    send(3'd7, 8'hFF, 8'hFF, 8'h01, 1'b0, 1'b1, 8, 0, 1'b0);
    send(3'd0, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0, 0, 0, 1'b0);

    @(posedge clk); #1;
    bus.op = 3'd7; bus.a = 8'd13; bus.b = 8'd11; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midmul_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midmul_g",         32'(bus.g),         32'd0);
    chk("midmul_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk); #1;
    rst = 1'b1;

    send(3'd0, 8'h3C, 8'h0F, 8'h33, 1'b0, 1'b0, 0, 0, 1'b0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, expected earlier finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_seq.md
Name:
alu_seq

Overview:
- Parametrised, registered successor to the team's 3-bit combinational XOR ALU.
- Eight-operation ALU of width WIDTH with valid/ready handshakes on input and output.
- Registered result plus zero and carry flags; MUL is multi-cycle (shift-add).
- Sits between the decode/branch logic and the writeback register in the project datapath.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- SHW, $clog2(WIDTH), width of the internal MUL iteration counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; one clock domain.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  block can accept; high only in IDLE.
- op  input  3  operation select (see Behaviour).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  g/zero/carry hold a valid result.
- out_ready  input  1  consumer takes the result.
- g  output  WIDTH  result.
- zero  output  1  high when g == 0.
- carry  output  1  carry/borrow/overflow flag.

Behaviour:
- Reset (rst low, async): state=IDLE, g=0, zero=0, carry=0, out_valid=0, in_ready=1, counter=0. Reset mid-MUL aborts the operation and discards the partial product.
- Accept on a rising edge with in_valid && in_ready; a, b and op are sampled on that edge.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, accept, op != 111 -> DONE. Result and flags are registered on the accept edge, so out_valid is high the next cycle (latency 1).
  - IDLE, accept, op == 111 -> BUSY. Operands are loaded, counter=WIDTH-1, accumulator=0.
  - BUSY: one shift-add step per edge. When the counter is 0 on an edge, that final step goes to DONE. out_valid rises WIDTH cycles after the accept edge.
  - DONE: g, zero, carry and out_valid hold stable until out_ready is high on an edge -> IDLE (out_valid=0 the next cycle).
- in_ready = (state == IDLE). There is no overlap: a new op is accepted no earlier than the cycle after the result is consumed.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- Op encoding and flags (all arithmetic modulo 2^WIDTH):
  - 000 XOR: g = a^b, carry = 0.
  - 001 AND: g = a&b, carry = 0.
  - 010 OR: g = a|b, carry = 0.
  - 011 ADD: g = a+b, carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - 100 SUB: g = a-b, carry = borrow (1 when a < b unsigned).
  - 101 SHL: g = a << b. If b >= WIDTH, g = 0. carry = 0.
  - 110 SHR: logical, g = a >> b. If b >= WIDTH, g = 0. carry = 0.
  - 111 MUL: g = low WIDTH bits of a*b (unsigned). carry = 1 if the high WIDTH bits of the 2*WIDTH product are nonzero.
- zero is computed from the final registered g of every op, including MUL.
- Outputs g, zero and carry change only on the edge that enters DONE, or on reset.

Test Plan:
- WIDTH=3 XOR regression: (001,011)->g=010; (101,001)->g=100; (111,111)->g=000 with zero=1. Each has out_valid 1 cycle after accept and carry=0.
- WIDTH=8 ADD/SUB: ADD 0xF0+0x20 -> g=0x10, carry=1. SUB 0x05-0x07 -> g=0xFE, carry=1. SUB 0x07-0x07 -> g=0x00, zero=1, carry=0.
- WIDTH=8 MUL: 13*11 -> g=0x8F, carry=0, out_valid exactly 8 cycles after accept, in_ready=0 throughout. 0x20*0x10 -> g=0x00, zero=1, carry=1.
- Backpressure: hold out_ready=0 for 5 cycles after DONE -> g, flags and out_valid stable, in_ready=0, and an in_valid pulse is not accepted. Raising out_ready -> IDLE the next cycle.
- Shifts: SHL 0x81 by 1 -> 0x02. SHR 0x81 by 7 -> 0x01. SHL by 8 -> 0x00 with zero=1.
- Reset mid-MUL: assert rst low 3 cycles into a MUL, asynchronously between edges. Required: out_valid=0, g=0 and in_ready=1 immediately. After release, a fresh XOR completes correctly.
